// File: rtl/multiplier_arbiter.sv
// multiplier_arbiter: round-robin front end that shares one sequential
// multiplier among NUM_REQ requesters and returns id-tagged products.
// Optional build macro MULT_ARB_ZERO_BYPASS_EN: a zero operand skips the
// multiplier and answers with product 0 directly.
module multiplier_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [2*WIDTH-1:0]       rsp_product,
  output logic                     mul_start,
  output logic [WIDTH-1:0]         mul_multiplicand,
  output logic [WIDTH-1:0]         mul_multiplier,
  input  logic [2*WIDTH-1:0]       mul_product,
  input  logic                     mul_done,
  output logic                     busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic [ID_W-1:0]      id_q, id_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic                 done_q;

  logic                 grant_vld;
  logic [ID_W-1:0]      grant_idx;
  logic [ID_W-1:0]      cand_idx;
  logic [WIDTH-1:0]     grant_a;
  logic [WIDTH-1:0]     grant_b;

  // Round-robin search: first valid requester after the last granted one.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand_idx  = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand_idx = ID_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!grant_vld && req_valid[cand_idx]) begin
        grant_vld = 1'b1;
        grant_idx = cand_idx;
      end
    end
    grant_a = req_a[grant_idx*WIDTH +: WIDTH];
    grant_b = req_b[grant_idx*WIDTH +: WIDTH];
  end

  // Next-state, operand/result capture and the IDLE-only accept strobe.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    a_d       = a_q;
    b_d       = b_q;
    prod_d    = prod_q;
    req_ready = '0;
    case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          req_ready[grant_idx] = 1'b1;
          a_d   = grant_a;
          b_d   = grant_b;
          id_d  = grant_idx;
          ptr_d = grant_idx;
`ifdef MULT_ARB_ZERO_BYPASS_EN
          if ((grant_a == '0) || (grant_b == '0)) begin
            prod_d  = '0;
            state_d = S_RESP;
          end else begin
            state_d = S_ISSUE;
          end
`else
          state_d = S_ISSUE;
`endif
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        // Only a fresh rising edge of done counts; a level left over from
        // the previous operation is ignored.
        if (mul_done && !done_q) begin
          prod_d  = mul_product;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= ID_W'(NUM_REQ - 1);
      id_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      prod_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      prod_q  <= prod_d;
      done_q  <= mul_done;
    end
  end

  assign mul_start        = (state_q == S_ISSUE);
  assign rsp_valid        = (state_q == S_RESP);
  assign busy             = (state_q != S_IDLE);
  assign rsp_id           = id_q;
  assign rsp_product      = prod_q;
  assign mul_multiplicand = a_q;
  assign mul_multiplier   = b_q;

endmodule

// File: tb/tb_multiplier_arbiter.sv
// Testbench for multiplier_arbiter with a behavioural sequential multiplier
// and an id/product scoreboard. Honours MULT_ARB_ZERO_BYPASS_EN.
module tb_multiplier_arbiter;

  localparam int N       = 4;
  localparam int W       = 32;
  localparam int MUL_LAT = 6;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a, req_b;
  logic [N-1:0]   req_ready;
  logic           rsp_valid, rsp_ready;
  logic [1:0]     rsp_id;
  logic [2*W-1:0] rsp_product;
  logic           mul_start;
  logic [W-1:0]   mul_multiplicand, mul_multiplier;
  logic [2*W-1:0] mul_product;
  logic           mul_done;
  logic           busy;

  typedef struct packed {
    logic [1:0]  id;
    logic [63:0] prod;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_err = 0;
  int starts = 0;
  int stale_hold = 0;

  multiplier_arbiter #(.NUM_REQ(N), .WIDTH(W), .ID_W(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_product(rsp_product), .mul_start(mul_start),
    .mul_multiplicand(mul_multiplicand), .mul_multiplier(mul_multiplier),
    .mul_product(mul_product), .mul_done(mul_done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural sequential multiplier: done drops on start (or stale_hold
  // cycles later) and rises MUL_LAT cycles after start with the product.
  logic [W-1:0] m_a, m_b;
  int           m_cnt, m_hold;

  function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
    longint x, y;
    x = longint'($signed(a));
    y = longint'($signed(b));
    return 64'(x * y);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_done <= 1'b0; mul_product <= '0; m_cnt <= 0; m_hold <= 0;
      m_a <= '0; m_b <= '0;
    end else if (mul_start) begin
      m_a <= mul_multiplicand; m_b <= mul_multiplier;
      m_cnt <= MUL_LAT; m_hold <= stale_hold;
      if (stale_hold == 0) mul_done <= 1'b0;
    end else begin
      if (m_hold > 0) begin
        m_hold <= m_hold - 1;
        if (m_hold == 1) mul_done <= 1'b0;
      end
      if (m_cnt > 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          mul_done <= 1'b1;
          mul_product <= smul(m_a, m_b);
        end
      end
    end
  end

  always @(posedge clk) if (!rst && mul_start) starts <= starts + 1;

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
    req_valid[i] = 1'b1;
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  task automatic wait_grant(output logic [N-1:0] g, output logic ok);
    ok = 1'b0; g = '0;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (req_ready != '0) begin g = req_ready; ok = 1'b1; break; end
      @(posedge clk);
    end
  endtask

  task automatic wait_rsp(output logic ok, output logic [1:0] id,
                          output logic [63:0] prod, output int cyc);
    ok = 1'b0; id = '0; prod = '0; cyc = 0;
    for (int i = 0; i < 100; i++) begin
      if (rsp_valid) begin ok = 1'b1; id = rsp_id; prod = rsp_product; break; end
      tick(); cyc++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    tick(); tick();
    n_cmp++;
    if ({req_ready, rsp_valid, rsp_id, rsp_product, mul_start, mul_multiplicand,
         mul_multiplier, busy} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: rr=%b rv=%b id=%0d p=%h st=%b a=%h b=%h busy=%b expected all 0",
               req_ready, rsp_valid, rsp_id, rsp_product, mul_start, mul_multiplicand,
               mul_multiplier, busy);
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if (busy !== 1'b0 || req_ready !== '0) begin
      n_err++; $display("FAIL reset_idle: busy=%b rr=%b expected 0/0000", busy, req_ready);
    end
  endtask

  task automatic test_single;
    int s0, cyc; logic ok; logic [1:0] id; logic [63:0] p; exp_t e;
    s0 = starts;
    set_req(0, 32'd5, 32'hFFFF_FFFD);
    sb.push_back('{2'd0, 64'hFFFF_FFFF_FFFF_FFF1});
    #1;
    n_cmp++;
    if (req_ready !== 4'b0001) begin
      n_err++; $display("FAIL t1_grant: req_ready=%b expected 0001", req_ready);
    end
    tick(); req_valid[0] = 1'b0;
    n_cmp++;
    if (req_ready !== 4'b0000 || mul_start !== 1'b1 || mul_multiplicand !== 32'd5 ||
        mul_multiplier !== 32'hFFFF_FFFD) begin
      n_err++;
      $display("FAIL t1_issue: rr=%b start=%b a=%h b=%h expected 0000/1/00000005/fffffffd",
               req_ready, mul_start, mul_multiplicand, mul_multiplier);
    end
    tick();
    n_cmp++;
    if (mul_start !== 1'b0) begin
      n_err++; $display("FAIL t1_start_pulse: mul_start=%b expected 0", mul_start);
    end
    wait_rsp(ok, id, p, cyc);
    e = sb.pop_front();
    n_cmp++;
    if (!ok || id !== e.id || p !== e.prod) begin
      n_err++; $display("FAIL t1_rsp: ok=%b id=%0d prod=%h expected id=%0d prod=%h",
                        ok, id, p, e.id, e.prod);
    end
    n_cmp++;
    if (cyc + 1 !== MUL_LAT + 2) begin
      n_err++; $display("FAIL t1_latency: cycles=%0d expected %0d", cyc + 1, MUL_LAT + 2);
    end
    tick();
    n_cmp++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || starts - s0 !== 1) begin
      n_err++; $display("FAIL t1_end: rv=%b busy=%b starts=%0d expected 0/0/1",
                        rsp_valid, busy, starts - s0);
    end
  endtask

  task automatic test_round_robin;
    int ord[5];
    logic [63:0] pr[4];
    logic [N-1:0] g; logic ok, rok; logic [1:0] id; logic [63:0] p; int cyc; exp_t e;
    ord = '{0, 1, 2, 3, 0};
    pr  = '{64'd28, 64'd24, 64'hFFFF_FFFF_FFFF_FFD8, 64'h0000_0001_0000_0000};
    rst = 1'b1; tick(); rst = 1'b0;
    set_req(0, 32'd4, 32'd7);
    set_req(1, 32'hFFFF_FFFA, 32'hFFFF_FFFC);
    set_req(2, 32'hFFFF_FFF8, 32'd5);
    set_req(3, 32'd65536, 32'd65536);
    for (int k = 0; k < 5; k++) begin
      wait_grant(g, ok);
      n_cmp++;
      if (!ok || g !== (4'b0001 << ord[k])) begin
        n_err++; $display("FAIL t2_grant_%0d: req_ready=%b expected %b", k, g, 4'b0001 << ord[k]);
      end
      sb.push_back('{2'(ord[k]), pr[ord[k]]});
      tick();
      if (k == 4) req_valid = '0;
      wait_rsp(rok, id, p, cyc);
      e = sb.pop_front();
      n_cmp++;
      if (!rok || id !== e.id || p !== e.prod) begin
        n_err++; $display("FAIL t2_rsp_%0d: ok=%b id=%0d prod=%h expected id=%0d prod=%h",
                          k, rok, id, p, e.id, e.prod);
      end
      tick();
      n_cmp++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
        n_err++; $display("FAIL t2_idle_gap_%0d: rv=%b busy=%b expected 0/0", k, rsp_valid, busy);
      end
    end
  endtask

  task automatic test_hold;
    logic [N-1:0] g; logic ok; logic [1:0] id; logic [63:0] p; int cyc; exp_t e;
    rsp_ready = 1'b0;
    set_req(2, 32'h8000_0000, 32'h8000_0000);
    wait_grant(g, ok);
    n_cmp++;
    if (!ok || g !== 4'b0100) begin
      n_err++; $display("FAIL t3_grant: req_ready=%b expected 0100", g);
    end
    sb.push_back('{2'd2, 64'h4000_0000_0000_0000});
    tick(); req_valid[2] = 1'b0;
    set_req(0, 32'd1, 32'd1);
    wait_rsp(ok, id, p, cyc);
    e = sb.pop_front();
    n_cmp++;
    if (!ok || id !== e.id || p !== e.prod) begin
      n_err++; $display("FAIL t3_rsp: ok=%b id=%0d prod=%h expected id=%0d prod=%h",
                        ok, id, p, e.id, e.prod);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_product !== 64'h4000_0000_0000_0000 ||
          req_ready !== 4'b0000) begin
        n_err++; $display("FAIL t3_hold_%0d: rv=%b id=%0d prod=%h rr=%b expected 1/2/4000000000000000/0000",
                          i, rsp_valid, rsp_id, rsp_product, req_ready);
      end
    end
    rsp_ready = 1'b1;
    tick();
    n_cmp++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'b0001) begin
      n_err++; $display("FAIL t3_release: rv=%b rr=%b expected 0/0001", rsp_valid, req_ready);
    end
    sb.push_back('{2'd0, 64'd1});
    tick(); req_valid[0] = 1'b0;
    wait_rsp(ok, id, p, cyc);
    e = sb.pop_front();
    n_cmp++;
    if (!ok || id !== e.id || p !== e.prod) begin
      n_err++; $display("FAIL t3_rsp2: ok=%b id=%0d prod=%h expected id=%0d prod=%h",
                        ok, id, p, e.id, e.prod);
    end
    tick();
  endtask

  task automatic test_reset_abort;
    logic [N-1:0] g; logic ok; logic [1:0] id; logic [63:0] p; int cyc; exp_t e;
    set_req(1, 32'd3, 32'd3);
    wait_grant(g, ok);
    tick(); req_valid[1] = 1'b0;
    tick(); tick();
    n_cmp++;
    if (busy !== 1'b1 || mul_multiplicand !== 32'd3) begin
      n_err++; $display("FAIL t4_pre: busy=%b a=%h expected 1/00000003", busy, mul_multiplicand);
    end
    rst = 1'b1;
    tick();
    n_cmp++;
    if ({req_ready, rsp_valid, rsp_id, rsp_product, mul_start, mul_multiplicand,
         mul_multiplier, busy} !== '0) begin
      n_err++;
      $display("FAIL t4_abort_outputs: rr=%b rv=%b id=%0d p=%h st=%b a=%h b=%h busy=%b expected all 0",
               req_ready, rsp_valid, rsp_id, rsp_product, mul_start, mul_multiplicand,
               mul_multiplier, busy);
    end
    set_req(3, 32'hFFFF_FFFF, 32'd9);
    set_req(0, 32'd2, 32'd3);
    rst = 1'b0;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0001) begin
      n_err++; $display("FAIL t4_ptr_reset: req_ready=%b expected 0001", req_ready);
    end
    sb.push_back('{2'd0, 64'd6});
    tick(); req_valid[0] = 1'b0;
    wait_rsp(ok, id, p, cyc);
    e = sb.pop_front();
    n_cmp++;
    if (!ok || id !== e.id || p !== e.prod) begin
      n_err++; $display("FAIL t4_rsp0: ok=%b id=%0d prod=%h expected id=%0d prod=%h",
                        ok, id, p, e.id, e.prod);
    end
    tick();
    wait_grant(g, ok);
    n_cmp++;
    if (!ok || g !== 4'b1000) begin
      n_err++; $display("FAIL t4_grant3: req_ready=%b expected 1000", g);
    end
    sb.push_back('{2'd3, 64'hFFFF_FFFF_FFFF_FFF7});
    tick(); req_valid[3] = 1'b0;
    wait_rsp(ok, id, p, cyc);
    e = sb.pop_front();
    n_cmp++;
    if (!ok || id !== e.id || p !== e.prod) begin
      n_err++; $display("FAIL t4_rsp3: ok=%b id=%0d prod=%h expected id=%0d prod=%h",
                        ok, id, p, e.id, e.prod);
    end
    tick();
  endtask

  task automatic test_zero_operand;
    logic [N-1:0] g; logic ok; logic [1:0] id; logic [63:0] p; int cyc, s0; exp_t e;
    s0 = starts;
    set_req(1, 32'd123, 32'd0);
    wait_grant(g, ok);
    n_cmp++;
    if (!ok || g !== 4'b0010) begin
      n_err++; $display("FAIL t5_grant: req_ready=%b expected 0010", g);
    end
    sb.push_back('{2'd1, 64'd0});
    tick(); req_valid[1] = 1'b0;
`ifdef MULT_ARB_ZERO_BYPASS_EN
    n_cmp++;
    if (rsp_valid !== 1'b1 || mul_start !== 1'b0) begin
      n_err++; $display("FAIL t5_bypass: rv=%b start=%b expected 1/0", rsp_valid, mul_start);
    end
`else
    n_cmp++;
    if (mul_start !== 1'b1 || rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL t5_issue: start=%b rv=%b expected 1/0", mul_start, rsp_valid);
    end
`endif
    wait_rsp(ok, id, p, cyc);
    e = sb.pop_front();
    n_cmp++;
    if (!ok || id !== e.id || p !== e.prod) begin
      n_err++; $display("FAIL t5_rsp: ok=%b id=%0d prod=%h expected id=%0d prod=%h",
                        ok, id, p, e.id, e.prod);
    end
    tick();
    n_cmp++;
`ifdef MULT_ARB_ZERO_BYPASS_EN
    if (starts - s0 !== 0) begin
      n_err++; $display("FAIL t5_starts: starts=%0d expected 0", starts - s0);
    end
`else
    if (starts - s0 !== 1) begin
      n_err++; $display("FAIL t5_starts: starts=%0d expected 1", starts - s0);
    end
`endif
  endtask

  task automatic test_stale_done;
    logic [N-1:0] g; logic ok; logic [1:0] id; logic [63:0] p; int cyc; exp_t e;
    stale_hold = 3;
    set_req(2, 32'd7, 32'hFFFF_FFF7);
    wait_grant(g, ok);
    n_cmp++;
    if (!ok || g !== 4'b0100 || mul_done !== 1'b1) begin
      n_err++; $display("FAIL t6_grant: req_ready=%b mul_done=%b expected 0100/1", g, mul_done);
    end
    sb.push_back('{2'd2, 64'hFFFF_FFFF_FFFF_FFC1});
    tick(); req_valid[2] = 1'b0;
    wait_rsp(ok, id, p, cyc);
    e = sb.pop_front();
    n_cmp++;
    if (!ok || id !== e.id || p !== e.prod) begin
      n_err++; $display("FAIL t6_rsp: ok=%b id=%0d prod=%h expected id=%0d prod=%h",
                        ok, id, p, e.id, e.prod);
    end
    n_cmp++;
    if (cyc !== MUL_LAT + 2) begin
      n_err++; $display("FAIL t6_latency: cycles=%0d expected %0d", cyc, MUL_LAT + 2);
    end
    stale_hold = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_hold();
    test_reset_abort();
    test_zero_operand();
    test_stale_done();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before end of tests");
    $fatal(1, "watchdog");
  end

endmodule
